microcode_sequencer: RTL and testbench

//  Control unit that produces the CPU's 42-bit control-signal word each cycle.
//  It holds the instruction register (IR) and a micro-step counter, and indexes a

---
 rtl/microcode_sequencer_pkg.sv | 89 ++++++++
 rtl/microcode_sequencer_rom.sv | 17 +
 rtl/microcode_sequencer.sv | 119 +++++++++++
 tb/tb_microcode_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/microcode_sequencer_pkg.sv
// Shared constants for the microcode sequencer: control-bit positions, ROM word layout,
// FSM encodings and the microprogram image. COND_BRANCH_EN adds ALU flags to the ROM index.
package microcode_sequencer_pkg;

    localparam int MC_SIG_WIDTH    = 42;
    localparam int MC_OPCODE_WIDTH = 8;
    localparam int MC_STEP_WIDTH   = 4;
    localparam int MC_FLAG_WIDTH   = 4;
    localparam int MC_WORD_WIDTH   = MC_SIG_WIDTH + 2;
    localparam int MC_ROM_AW_MAX   = MC_FLAG_WIDTH + MC_OPCODE_WIDTH + MC_STEP_WIDTH;

    // Control-word bit positions; END and HLT sit just above the datapath signals.
    localparam int SIG_PC_TICK    = 0;
    localparam int SIG_PC_LOAD    = 1;
    localparam int SIG_PC_OUT     = 2;
    localparam int SIG_REG_A_LOAD = 3;
    localparam int SIG_REG_B_LOAD = 4;
    localparam int SIG_ALU_OUT    = 5;
    localparam int SIG_MEM_OUT    = 7;
    localparam int SIG_MAR_LOAD   = 9;
    localparam int SIG_DIAG_LSB   = 16;
    localparam int SIG_IR_LOAD    = 41;
    localparam int MC_END_BIT     = MC_SIG_WIDTH;
    localparam int MC_HLT_BIT     = MC_SIG_WIDTH + 1;

    // Flag vector is {V,N,Z,C}.
    localparam int FLAG_Z = 1;

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // Microprogram image indexed by {flags, opcode, step}. Steps 0..1 are the shared fetch.
    function automatic logic [MC_WORD_WIDTH-1:0] microcode_word(
        input logic [MC_ROM_AW_MAX-1:0] addr
    );
        logic [MC_FLAG_WIDTH-1:0]   flags;
        logic [MC_OPCODE_WIDTH-1:0] op;
        logic [MC_STEP_WIDTH-1:0]   st;
        logic [MC_WORD_WIDTH-1:0]   w;
        flags = addr[MC_ROM_AW_MAX-1 -: MC_FLAG_WIDTH];
        op    = addr[MC_STEP_WIDTH +: MC_OPCODE_WIDTH];
        st    = addr[MC_STEP_WIDTH-1:0];
        w     = '0;
        if (st == 4'd0) begin
            w[SIG_PC_OUT]   = 1'b1;
            w[SIG_MAR_LOAD] = 1'b1;
        end else if (st == 4'd1) begin
            w[SIG_MEM_OUT]  = 1'b1;
            w[SIG_IR_LOAD]  = 1'b1;
            w[SIG_PC_TICK]  = 1'b1;
        end else begin
            case (op)
                // Diagnostic opcode: never ends, shows its step on the diag nibble.
                8'h07: begin
                    w[SIG_REG_A_LOAD] = 1'b1;
                    w[SIG_DIAG_LSB +: MC_STEP_WIDTH] = st;
                end
                8'h2A: begin
                    if (st == 4'd2) begin
                        w[SIG_MEM_OUT]    = 1'b1;
                        w[SIG_REG_A_LOAD] = 1'b1;
                    end else begin
                        w[SIG_ALU_OUT]    = 1'b1;
                        w[SIG_REG_B_LOAD] = 1'b1;
                        w[MC_END_BIT]     = 1'b1;
                    end
                end
                8'h30: begin
                    w[MC_END_BIT] = 1'b1;
                    if (flags[FLAG_Z]) begin
                        w[SIG_PC_LOAD] = 1'b1;
                        w[SIG_MEM_OUT] = 1'b1;
                    end else begin
                        w[SIG_PC_TICK] = 1'b1;
                    end
                end
                8'hFF: begin
                    w[MC_HLT_BIT]  = 1'b1;
                    w[MC_END_BIT]  = 1'b1;
                    w[SIG_PC_TICK] = 1'b1;
                end
                default: w[MC_END_BIT] = 1'b1;
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/microcode_sequencer_rom.sv
// Asynchronous-read microcode ROM; narrower address builds see the flag field as zero.
module microcode_sequencer_rom
    import microcode_sequencer_pkg::*;
#(
    parameter int WIDTH      = MC_WORD_WIDTH,
    parameter int ADDR_WIDTH = MC_OPCODE_WIDTH + MC_STEP_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      data
);

    logic [MC_ROM_AW_MAX-1:0] full_addr;

    assign full_addr = MC_ROM_AW_MAX'(addr);
    assign data      = WIDTH'(microcode_word(full_addr));

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: IR, micro-step counter and START/RUN/HALT FSM driving the
// registered control word. Define COND_BRANCH_EN to index the ROM with ALU flags.
module microcode_sequencer
    import microcode_sequencer_pkg::*;
#(
    parameter int SIG_WIDTH    = MC_SIG_WIDTH,
    parameter int OPCODE_WIDTH = MC_OPCODE_WIDTH,
    parameter int STEP_WIDTH   = MC_STEP_WIDTH,
    parameter int IR_LOAD_BIT  = SIG_IR_LOAD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] bus_in,
`ifdef COND_BRANCH_EN
    input  logic [3:0]              flags_in,
`endif
    output logic [SIG_WIDTH-1:0]    signals,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [STEP_WIDTH-1:0]   step,
    output logic                    halted,
    output logic                    step_err
);

`ifdef COND_BRANCH_EN
    localparam int ROM_AW = MC_FLAG_WIDTH + OPCODE_WIDTH + STEP_WIDTH;
`else
    localparam int ROM_AW = OPCODE_WIDTH + STEP_WIDTH;
`endif
    localparam int WORD_W = SIG_WIDTH + 2;

    logic [1:0]              state_q, state_d;
    logic [WORD_W-1:0]       word_q, word_d;
    logic [OPCODE_WIDTH-1:0] ir_q, ir_d, ir_next;
    logic [STEP_WIDTH-1:0]   step_q, step_d, step_next;
    logic                    step_err_q, step_err_d;
    logic [ROM_AW-1:0]       rom_addr;
    logic [WORD_W-1:0]       rom_word;

    microcode_sequencer_rom #(
        .WIDTH      (WORD_W),
        .ADDR_WIDTH (ROM_AW)
    ) u_rom (
        .addr (rom_addr),
        .data (rom_word)
    );

    // The IR load lands on the same edge that selects the new opcode's word.
    always_comb begin
        ir_next   = word_q[IR_LOAD_BIT] ? bus_in : ir_q;
        step_next = word_q[SIG_WIDTH] ? '0 : step_q + 1'b1;
        if (state_q == ST_START) begin
            rom_addr = '0;
        end else begin
`ifdef COND_BRANCH_EN
            rom_addr = {flags_in, ir_next, step_next};
`else
            rom_addr = {ir_next, step_next};
`endif
        end
    end

    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch is inferred.
        state_d    = state_q;
        word_d     = word_q;
        ir_d       = ir_q;
        step_d     = step_q;
        step_err_d = step_err_q;
        case (state_q)
            ST_START: begin
                word_d  = rom_word;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // HLT outranks END; IR and step freeze where they are.
                if (word_q[SIG_WIDTH+1]) begin
                    word_d  = '0;
                    state_d = ST_HALT;
                end else begin
                    ir_d   = ir_next;
                    step_d = step_next;
                    word_d = rom_word;
                    if (!word_q[SIG_WIDTH] && (&step_q)) begin
                        step_err_d = 1'b1;
                    end
                end
            end
            ST_HALT: word_d = '0;
            default: begin
                word_d  = '0;
                state_d = ST_START;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_START;
            word_q     <= '0;
            ir_q       <= '0;
            step_q     <= '0;
            step_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            ir_q       <= ir_d;
            step_q     <= step_d;
            step_err_q <= step_err_d;
        end
    end

    assign signals  = word_q[SIG_WIDTH-1:0];
    assign opcode   = ir_q;
    assign step     = step_q;
    assign halted   = (state_q == ST_HALT);
    assign step_err = step_err_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer: a cycle-by-cycle vector table through fetch,
// END, step wrap and HLT, plus hand sequences for halt hold, async reset and flag branching.
module tb_microcode_sequencer;

    localparam logic [41:0] F0     = 42'h204;                  // PC_OUT | MAR_LOAD
    localparam logic [41:0] F1     = (42'd1 << 41) | 42'h81;   // IR_LOAD | MEM_OUT | PC_TICK
    localparam logic [41:0] W2A2   = 42'h88;                   // MEM_OUT | REG_A_LOAD
    localparam logic [41:0] W2A3   = 42'h30;                   // ALU_OUT | REG_B_LOAD
    localparam logic [41:0] WFF2   = 42'h1;                    // PC_TICK (HLT/END above bit 41)
    localparam logic [41:0] W30_Z  = 42'h82;                   // PC_LOAD | MEM_OUT
    localparam logic [41:0] W30_NZ = 42'h1;                    // PC_TICK
    localparam int          NV     = 27;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  bus_in;
`ifdef COND_BRANCH_EN
    logic [3:0]  flags_in;
`endif
    logic [41:0] signals;
    logic [7:0]  opcode;
    logic [3:0]  step;
    logic        halted;
    logic        step_err;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0]  bus;
        logic [41:0] sig;
        logic [7:0]  op;
        logic [3:0]  st;
        logic        hlt;
        logic        err;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    microcode_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .bus_in   (bus_in),
`ifdef COND_BRANCH_EN
        .flags_in (flags_in),
`endif
        .signals  (signals),
        .opcode   (opcode),
        .step     (step),
        .halted   (halted),
        .step_err (step_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [41:0] sig, input logic [7:0] op,
                                 input logic [3:0] st, input logic hlt, input logic err);
        check({tag, ".signals"},  64'(signals),  64'(sig));
        check({tag, ".opcode"},   64'(opcode),   64'(op));
        check({tag, ".step"},     64'(step),     64'(st));
        check({tag, ".halted"},   64'(halted),   64'(hlt));
        check({tag, ".step_err"}, 64'(step_err), 64'(err));
    endtask

    function automatic logic [41:0] w07(input int s);
        return 42'h8 | (42'(s) << 16);
    endfunction

    // Reset, release, then run fetch and load `op` into the IR; returns with step 2 visible.
    task automatic run_to_step2(input logic [7:0] op);
        reset  = 1'b1;
        bus_in = 8'h00;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus_in = op;
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0]  = '{8'h00, F0,   8'h00, 4'd0, 1'b0, 1'b0};
        vecs[1]  = '{8'h00, F1,   8'h00, 4'd1, 1'b0, 1'b0};
        vecs[2]  = '{8'h2A, W2A2, 8'h2A, 4'd2, 1'b0, 1'b0};
        vecs[3]  = '{8'h00, W2A3, 8'h2A, 4'd3, 1'b0, 1'b0};
        vecs[4]  = '{8'h00, F0,   8'h2A, 4'd0, 1'b0, 1'b0};
        vecs[5]  = '{8'h00, F1,   8'h2A, 4'd1, 1'b0, 1'b0};
        for (int s = 2; s <= 15; s++) begin
            vecs[4+s] = '{(s == 2) ? 8'h07 : 8'h00, w07(s), 8'h07, 4'(s), 1'b0, 1'b0};
        end
        vecs[20] = '{8'h00, F0,    8'h07, 4'd0, 1'b0, 1'b1};
        vecs[21] = '{8'h00, F1,    8'h07, 4'd1, 1'b0, 1'b1};
        vecs[22] = '{8'h00, 42'h0, 8'h00, 4'd2, 1'b0, 1'b1};
        vecs[23] = '{8'h00, F0,    8'h00, 4'd0, 1'b0, 1'b1};
        vecs[24] = '{8'h00, F1,    8'h00, 4'd1, 1'b0, 1'b1};
        vecs[25] = '{8'hFF, WFF2,  8'hFF, 4'd2, 1'b0, 1'b1};
        vecs[26] = '{8'h00, 42'h0, 8'hFF, 4'd2, 1'b1, 1'b1};

        reset  = 1'b1;
        bus_in = 8'h00;
`ifdef COND_BRANCH_EN
        flags_in = 4'b0000;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 42'h0, 8'h00, 4'd0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check_outputs("start", 42'h0, 8'h00, 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            bus_in = vecs[i].bus;
            @(posedge clk); #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].sig, vecs[i].op, vecs[i].st,
                          vecs[i].hlt, vecs[i].err);
        end

        // HALT holds regardless of bus activity until reset.
        for (int c = 0; c < 20; c++) begin
            bus_in = 8'($urandom);
            @(posedge clk); #1;
            check_outputs($sformatf("halt_hold%0d", c), 42'h0, 8'hFF, 4'd2, 1'b1, 1'b1);
        end
        #2;
        reset = 1'b1;
        #1;
        check_outputs("halt_reset", 42'h0, 8'h00, 4'd0, 1'b0, 1'b0);

        // Reset asserted in the middle of step 2 clears everything without a clock edge.
        run_to_step2(8'h2A);
        check_outputs("pre_mid_reset", W2A2, 8'h2A, 4'd2, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_outputs("mid_reset", 42'h0, 8'h00, 4'd0, 1'b0, 1'b0);

`ifdef COND_BRANCH_EN
        flags_in = 4'b0010;
        run_to_step2(8'h30);
        check("jz_taken", 64'(signals), 64'(W30_Z));
        flags_in = 4'b0000;
        run_to_step2(8'h30);
        check("jz_not_taken", 64'(signals), 64'(W30_NZ));
`else
        run_to_step2(8'h30);
        check("jz_no_flags", 64'(signals), 64'(W30_NZ));
        check("jz_opcode", 64'(opcode), 64'h30);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
